// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch buffer: issues word fetches under a credit limit,
// queues returned instructions with their PCs, and discards in-flight fetches on redirect.
module if_prefetch #(
  parameter int unsigned        BITSIZE  = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [BITSIZE-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               resetn_i,
  output logic               mem_req_o,
  output logic [BITSIZE-1:0] mem_addr_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [31:0]        mem_rdata_i,
  input  logic               flush_i,
  input  logic [BITSIZE-1:0] flush_pc_i,
  input  logic               ID_IF_get_i,
  output logic               IF_ID_give_o,
  output logic [31:0]        IF_ID_instr_o,
  output logic [BITSIZE-1:0] IF_ID_pc_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [BITSIZE-1:0] fpc_q, fpc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      out_q, out_d;
  logic [CW-1:0]      discard_q, discard_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;

  logic [31:0]        buf_instr [DEPTH];
  logic [BITSIZE-1:0] buf_pc    [DEPTH];
  logic [BITSIZE-1:0] pq_pc     [DEPTH];

  logic req, grant, give, push, pop;

  // resetn_i gates the request so it is forced low while reset is held
  assign req   = resetn_i && (state_q == FETCH) &&
                 (({1'b0, count_q} + {1'b0, out_q}) < DEPTH_W);
  assign grant = req && mem_gnt_i;
  assign give  = (count_q != '0) && !flush_i;
  assign pop   = give && ID_IF_get_i;
  assign push  = mem_rvalid_i && (state_q == FETCH) && !flush_i;

  assign mem_req_o     = req;
  assign mem_addr_o    = fpc_q;
  assign IF_ID_give_o  = give;
  assign IF_ID_instr_o = give ? buf_instr[rd_ptr_q] : '0;
  assign IF_ID_pc_o    = give ? buf_pc[rd_ptr_q]    : '0;

  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    out_d     = out_q + CW'(grant) - CW'(mem_rvalid_i);
    discard_d = discard_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    pq_rd_d   = pq_rd_q;
    pq_wr_d   = pq_wr_q;

    if (grant) begin
      fpc_d   = fpc_q + BITSIZE'(4);
      pq_wr_d = pq_wr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      pq_rd_d  = pq_rd_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if ((state_q == DRAIN) && mem_rvalid_i) begin
      discard_d = discard_q - CW'(1);
      if (discard_d == '0) state_d = FETCH;
    end

    // A redirect discards everything still in flight, including a grant taken this cycle
    if (flush_i) begin
      fpc_d     = flush_pc_i;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      pq_rd_d   = '0;
      pq_wr_d   = '0;
      discard_d = out_d;
      state_d   = (out_d != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= FETCH;
      fpc_q     <= RESET_PC;
      count_q   <= '0;
      out_q     <= '0;
      discard_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      pq_rd_q   <= '0;
      pq_wr_q   <= '0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      count_q   <= count_d;
      out_q     <= out_d;
      discard_q <= discard_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      pq_rd_q   <= pq_rd_d;
      pq_wr_q   <= pq_wr_d;
    end
  end

  // Storage needs no reset: entries are only visible through the valid counters
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr_q] <= mem_rdata_i;
      buf_pc[wr_ptr_q]    <= pq_pc[pq_rd_q];
    end
    if (grant) begin
      pq_pc[pq_wr_q] <= fpc_q;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Randomized bench for if_prefetch: an in-order memory model drives responses and a
// queue-based reference model predicts every output each cycle.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        resetn_i = 1'b1;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        ID_IF_get_i = 1'b0;
  logic        IF_ID_give_o;
  logic [31:0] IF_ID_instr_o;
  logic [31:0] IF_ID_pc_o;

  if_prefetch #(.BITSIZE(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .resetn_i     (resetn_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .ID_IF_get_i  (ID_IF_get_i),
    .IF_ID_give_o (IF_ID_give_o),
    .IF_ID_instr_o(IF_ID_instr_o),
    .IF_ID_pc_o   (IF_ID_pc_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory side: addresses granted and not yet answered, in order
  logic [31:0] pending[$];

  // Reference model
  logic [31:0] m_fpc;
  int          m_out;
  int          m_disc;
  logic [31:0] m_pcq[$];
  logic [31:0] m_ins[$];
  logic [31:0] m_pcs[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
  endfunction

  task automatic model_clear();
    m_fpc  = 32'h0;
    m_out  = 0;
    m_disc = 0;
    m_pcq.delete();
    m_ins.delete();
    m_pcs.delete();
    pending.delete();
  endtask

  task automatic do_reset();
    resetn_i     = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    flush_i      = 1'b0;
    ID_IF_get_i  = 1'b0;
    #1;
    chk("rst_req",   {31'b0, mem_req_o},    32'h0);
    chk("rst_give",  {31'b0, IF_ID_give_o}, 32'h0);
    chk("rst_instr", IF_ID_instr_o,         32'h0);
    chk("rst_pc",    IF_ID_pc_o,            32'h0);
    chk("rst_addr",  mem_addr_o,            32'h0);
    repeat (2) @(negedge clk);
    model_clear();
    resetn_i = 1'b1;
  endtask

  // One cycle: drive at the falling edge, compare, then advance the model.
  // A redirect target of 1 selects a random target instead.
  task automatic step(input int pg, input int pr, input int pget, input int pfl,
                      input logic [31:0] fpc_sel);
    bit          ereq, egive, r, g;
    logic [31:0] ei, ep, pcr;
    r = (pending.size() != 0) && (int'($urandom_range(99)) < pr);
    mem_gnt_i    = int'($urandom_range(99)) < pg;
    mem_rvalid_i = r;
    mem_rdata_i  = r ? mdata(pending[0]) : $urandom();
    ID_IF_get_i  = int'($urandom_range(99)) < pget;
    flush_i      = int'($urandom_range(99)) < pfl;
    if (fpc_sel != 32'h1)            flush_pc_i = fpc_sel;
    else if ($urandom_range(9) == 0) flush_pc_i = 32'hFFFF_FFFC;
    else                             flush_pc_i = $urandom() & 32'hFFFF_FFFC;
    #1;
    ereq  = (m_disc == 0) && (m_ins.size() + m_out < 4);
    egive = (m_ins.size() != 0) && !flush_i;
    ei    = egive ? m_ins[0] : 32'h0;
    ep    = egive ? m_pcs[0] : 32'h0;
    chk("req",   {31'b0, mem_req_o},    {31'b0, ereq});
    chk("addr",  mem_addr_o,            m_fpc);
    chk("give",  {31'b0, IF_ID_give_o}, {31'b0, egive});
    chk("instr", IF_ID_instr_o,         ei);
    chk("pc",    IF_ID_pc_o,            ep);

    if (mem_req_o && mem_gnt_i) pending.push_back(mem_addr_o);
    if (r) void'(pending.pop_front());

    g = ereq && mem_gnt_i;
    if (egive && ID_IF_get_i) begin
      void'(m_ins.pop_front());
      void'(m_pcs.pop_front());
    end
    if (r) begin
      m_out--;
      if (m_disc > 0) m_disc--;
      else if (m_pcq.size() != 0) begin
        pcr = m_pcq.pop_front();
        m_ins.push_back(mem_rdata_i);
        m_pcs.push_back(pcr);
      end
    end
    if (g) begin
      m_pcq.push_back(m_fpc);
      m_fpc = m_fpc + 32'd4;
      m_out++;
    end
    if (flush_i) begin
      m_ins.delete();
      m_pcs.delete();
      m_pcq.delete();
      m_fpc  = flush_pc_i;
      m_disc = m_out;
    end
    @(negedge clk);
  endtask

  task automatic mid_reset();
    bit filled = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_ins.size() != 0) begin
        filled = 1;
        break;
      end
      step(100, 100, 0, 0, 32'h1);
    end
    chk("fill_timeout", {31'b0, filled}, 32'h1);
    flush_i      = 1'b0;
    ID_IF_get_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    #1;
    chk("pre_give", {31'b0, IF_ID_give_o}, {31'b0, filled});
    #1;
    resetn_i = 1'b0;
    #1;
    chk("mid_req",   {31'b0, mem_req_o},    32'h0);
    chk("mid_give",  {31'b0, IF_ID_give_o}, 32'h0);
    chk("mid_instr", IF_ID_instr_o,         32'h0);
    chk("mid_pc",    IF_ID_pc_o,            32'h0);
    @(negedge clk);
    do_reset();
  endtask

  initial begin
    model_clear();
    #2;
    do_reset();

    // Streaming with full-rate grants, 1-cycle latency, consumer always ready
    for (int i = 0; i < 12; i++) step(100, 100, 100, 0, 32'h1);

    // Credit limit with a stalled consumer, then a single pop
    do_reset();
    for (int i = 0; i < 10; i++) step(100, 100, 0, 0, 32'h1);
    step(100, 100, 100, 0, 32'h1);
    for (int i = 0; i < 3; i++) step(100, 100, 0, 0, 32'h1);
    chk("credit_addr", mem_addr_o, 32'h14);
    chk("credit_req", {31'b0, mem_req_o}, 32'h0);

    // Redirect with two fetches in flight
    do_reset();
    for (int i = 0; i < 2; i++) step(100, 0, 0, 0, 32'h1);
    step(0, 0, 0, 100, 32'h100);
    chk("drain_req", {31'b0, mem_req_o}, 32'h0);
    chk("drain_addr", mem_addr_o, 32'h100);
    for (int i = 0; i < 10; i++) step(100, 100, 100, 0, 32'h1);

    // Redirect to the top of the address space, then wrap
    do_reset();
    step(0, 0, 0, 100, 32'hFFFF_FFFC);
    step(100, 0, 0, 0, 32'h1);
    chk("wrap_addr", mem_addr_o, 32'h0);
    for (int i = 0; i < 6; i++) step(100, 100, 100, 0, 32'h1);

    // Random traffic with periodic asynchronous resets
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) step(70, 60, 60, 5, 32'h1);
      mid_reset();
    end
    for (int i = 0; i < 500; i++) step(90, 40, 30, 3, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001: Parameter BITSIZE, default 32, width of the program counter and memory address.
REQ-002: Parameter DEPTH, default 4, number of entries in the prefetch buffer; power of two, at least 2.
REQ-003: Parameter RESET_PC, default 0, fetch address after reset.
REQ-004: clk  in  1  single clock; all state updates on the rising edge.
REQ-005: resetn_i  in  1  reset, asynchronous and active-low.
REQ-006: mem_req_o  out  1  fetch request to instruction memory.
REQ-007: mem_addr_o  out  BITSIZE  fetch address, word aligned.
REQ-008: mem_gnt_i  in  1  memory accepts the request this cycle.
REQ-009: mem_rvalid_i  in  1  read data valid; responses return in order, no earlier than 1 cycle after grant.
REQ-010: mem_rdata_i  in  32  instruction word.
REQ-011: flush_i  in  1  redirect request (branch or jump).
REQ-012: flush_pc_i  in  BITSIZE  redirect target, word aligned.
REQ-013: ID_IF_get_i  in  1  decode stage ready to take an instruction.
REQ-014: IF_ID_give_o  out  1  buffer head is valid.
REQ-015: IF_ID_instr_o  out  32  head instruction.
REQ-016: IF_ID_pc_o  out  BITSIZE  address of the head instruction.

Function
REQ-017: The block SHALL keep a fetch PC (fpc); mem_addr_o SHALL equal fpc.
REQ-018: The block SHALL count outstanding requests (granted, response not yet received) and buffer occupancy (count).
REQ-019: mem_req_o SHALL be high only in state FETCH with count + outstanding < DEPTH.
REQ-020: Once raised, mem_req_o and mem_addr_o SHALL stay stable until mem_gnt_i, except on flush_i or reset.
REQ-021: On mem_req_o && mem_gnt_i, fpc SHALL advance by 4 and outstanding SHALL increment; back-to-back grants SHALL be supported.
REQ-022: fpc SHALL wrap modulo 2^BITSIZE with no error indication.
REQ-023: Each accepted response SHALL push {mem_rdata_i, its address} into the buffer; the address comes from a PC queue pushed at grant time.
REQ-024: A transfer SHALL occur when IF_ID_give_o && ID_IF_get_i in the same cycle; the head is popped at the next edge.
REQ-025: IF_ID_give_o SHALL equal (count != 0) && !flush_i.
REQ-026: IF_ID_instr_o and IF_ID_pc_o SHALL show the head entry while IF_ID_give_o is high, and 0 otherwise.
REQ-027: Push and pop in the same cycle SHALL leave count unchanged; a push when empty SHALL become visible the cycle after rvalid (1-cycle latency, no bypass).
REQ-028: Because of the credit rule in REQ-019, the buffer SHALL never overflow; a response arriving while full is a protocol error and need not be handled.
REQ-029: FSM states: FETCH, DRAIN.
REQ-030: FETCH -> DRAIN on flush_i when outstanding, after this cycle's grant and response, is nonzero.
REQ-031: On flush_i, whatever the state: buffer and PC queue cleared, fpc <= flush_pc_i, and the discard counter <= the resulting outstanding count (a grant in the flush cycle counts).
REQ-032: In DRAIN, mem_req_o SHALL be 0 and each response SHALL decrement the discard counter and be dropped.
REQ-033: DRAIN -> FETCH when the discard counter reaches 0; a further flush_i in DRAIN SHALL update fpc only.
REQ-034: flush_i and ID_IF_get_i together SHALL NOT transfer anything.
REQ-035: flush_i with no outstanding requests SHALL stay in FETCH and request flush_pc_i on the next cycle.

Reset
REQ-036: While resetn_i is low, the following SHALL be forced immediately, with no clock needed: state FETCH, fpc = RESET_PC, count = outstanding = discard = 0, mem_req_o = 0, IF_ID_give_o = 0, IF_ID_instr_o = 0, IF_ID_pc_o = 0.
REQ-037: mem_req_o SHALL first assert in the first cycle after resetn_i deasserts.
REQ-038: Reset during an outstanding transaction SHALL discard all state; later responses to the old transaction are the memory's responsibility.

Verification
REQ-039: Reset release, gnt tied high, rvalid 1 cycle later, get tied 1 -> requests to addresses 0x0, 0x4, 0x8; give from cycle 3 with pc 0x0, 0x4, 0x8 in order, one per cycle.
REQ-040: DEPTH=4, get held 0 -> exactly 4 grants, then mem_req_o low with count=4; one get pulse -> exactly one new request, to address 0x10.
REQ-041: 2 outstanding, flush_i with flush_pc_i=0x100 -> next 2 responses dropped, no request during DRAIN, then request 0x100; the first give shows pc 0x100.
REQ-042: flush_i and ID_IF_get_i high with a non-empty buffer -> IF_ID_give_o=0 and no pop; the buffer is empty on the next cycle.
REQ-043: resetn_i pulled low mid-cycle with give high -> give, req, instr and pc go to 0 before the next clock edge.
REQ-044: fpc=2^BITSIZE-4, one grant -> next mem_addr_o = 0x0.
